// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch sequencing controller.
//   - branch op encoding (matches the EX branch-condition unit)
//   - 2-bit bimodal counter values
//   - controller FSM state encoding
//   - small helpers for op classification and counter saturation
package branch_ctrl_pkg;

    localparam logic [2:0] BR_NO = 3'd0;
    localparam logic [2:0] BR_EQ = 3'd1;
    localparam logic [2:0] BR_NE = 3'd2;
    localparam logic [2:0] BR_GE = 3'd3;
    localparam logic [2:0] BR_LT = 3'd4;
    localparam logic [2:0] BR_GO = 3'd5;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } br_state_e;

    // Conditional branches are the only ones that train the BHT.
    function automatic logic is_cond(input logic [2:0] op);
        return (op >= BR_EQ) && (op <= BR_LT);
    endfunction

    // Encodings above BR_GO are not branches at all.
    function automatic logic is_branch(input logic [2:0] op);
        return (op != BR_NO) && (op <= BR_GO);
    endfunction

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == ST) ? ST : ctr + 2'd1;
        else
            return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Bimodal branch history table: 2**IDX_W saturating 2-bit counters.
//   clk, rst_n   : clock, async active-low reset (all entries -> WNT)
//   rd_idx/rd_ctr: combinational read port (sees pre-update value)
//   upd_en/upd_idx/upd_taken : synchronous saturating update port
module branch_bht
    import branch_ctrl_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0] ctr [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= WNT;
        end else if (upd_en) begin
            ctr[upd_idx] <= sat_update(ctr[upd_idx], upd_taken);
        end
    end

    assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch sequencing controller for the 5-stage pipeline.
// Predicts at ID from a bimodal BHT, resolves at EX against ex_f, and on a
// mispredict redirects fetch and flushes IF/ID + ID/EX for RECOVER_CYCLES.
// A predicted-taken ID branch redirects fetch and flushes IF/ID only.
//   stall                  : global stall, ID/EX events not consumed
//   id_*                   : decode-stage instruction, id_pred_taken out (comb)
//   ex_*                   : execute-stage branch and its carried prediction
//   redirect_valid/_pc     : registered fetch redirect
//   flush_ifid/flush_idex  : registered squash controls
//   br_cnt/miss_cnt        : wrapping resolved-branch / mispredict counters
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int BHT_IDX_W      = 6,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [2:0]  id_br_op,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_target,
    output logic        id_pred_taken,
    input  logic        ex_valid,
    input  logic [2:0]  ex_br_op,
    input  logic        ex_f,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    br_state_e          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic [1:0]         bht_rd;
    logic               resolved, mispredict, id_redirect;
    logic               rv_nxt, fi_nxt, fe_nxt;
    logic [31:0]        rpc_nxt;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{id_pc[31:BHT_IDX_W+2], id_pc[1:0],
                              ex_pc[31:BHT_IDX_W+2], ex_pc[1:0]};

    branch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (id_pc[BHT_IDX_W+1:2]),
        .rd_ctr    (bht_rd),
        .upd_en    (resolved && is_cond(ex_br_op)),
        .upd_idx   (ex_pc[BHT_IDX_W+1:2]),
        .upd_taken (ex_f)
    );

    // Unknown ops predict not-taken, same as they resolve.
    always_comb begin
        id_pred_taken = 1'b0;
        if (id_br_op == BR_GO)
            id_pred_taken = 1'b1;
        else if (is_cond(id_br_op))
            id_pred_taken = bht_rd[1];
    end

    assign resolved    = (state == ST_IDLE) && !stall && ex_valid && is_branch(ex_br_op);
    assign mispredict  = resolved && (ex_f != ex_pred_taken);
    // EX is the older instruction, so its mispredict shadows any ID redirect.
    assign id_redirect = (state == ST_IDLE) && !stall && id_valid && id_pred_taken && !mispredict;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; the recovery countdown ignores stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (mispredict) begin
                    state_nxt = ST_RECOVER;
                    cnt_nxt   = CNT_W'(RECOVER_CYCLES - 1);
                end
            end
            ST_RECOVER: begin
                if (cnt == '0)
                    state_nxt = ST_IDLE;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered controls. Flushes track
    // the upcoming state so they stay high for the whole recovery window.
    always_comb begin
        rv_nxt  = mispredict || id_redirect;
        fi_nxt  = (state_nxt == ST_RECOVER) || id_redirect;
        fe_nxt  = (state_nxt == ST_RECOVER);
        rpc_nxt = redirect_pc;
        if (mispredict)
            rpc_nxt = ex_f ? ex_target : ex_pc + 32'd4;
        else if (id_redirect)
            rpc_nxt = id_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_ifid     <= 1'b0;
            flush_idex     <= 1'b0;
            br_cnt         <= '0;
            miss_cnt       <= '0;
        end else begin
            redirect_valid <= rv_nxt;
            redirect_pc    <= rpc_nxt;
            flush_ifid     <= fi_nxt;
            flush_idex     <= fe_nxt;
            if (resolved)
                br_cnt <= br_cnt + 32'd1;
            if (mispredict)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

endmodule
